uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), pointer width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetq  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  input  1  write push_data into the queue this cycle.
REQ-006 SHALL have port push_data  input  8  byte to enqueue.
REQ-007 SHALL have port flush  input  1  discard all queued bytes.
REQ-008 SHALL have port clr_ovf  input  1  clear the overflow flag.
REQ-009 SHALL have port full  output  1  queue holds DEPTH bytes.
REQ-010 SHALL have port empty  output  1  queue holds 0 bytes.
REQ-011 SHALL have port level  output  AW+1  number of queued bytes, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky flag: a push was rejected.
REQ-013 SHALL have port uart_wr  output  1  one-cycle write strobe to the downstream UART transmitter.
REQ-014 SHALL have port uart_tx_data  output  8  byte presented with uart_wr.
REQ-015 SHALL have port uart_busy  input  1  downstream transmitter busy.

Function
REQ-016 Storage SHALL be a DEPTH x 8 circular buffer with AW-bit read and write pointers that wrap modulo DEPTH.
REQ-017 full, empty and level SHALL be derived from the registered state only, with no combinational path from push.
REQ-018 A push while !full SHALL store push_data at the write pointer, advance the pointer and raise level by 1 at the next edge.
REQ-019 A push while full SHALL be discarded and SHALL set overflow; this holds even if a pop occurs in the same cycle.
REQ-020 overflow SHALL stay set until a cycle with clr_ovf=1; if set and clear occur in the same cycle, set wins.
REQ-021 The drain FSM SHALL have three states: IDLE, ISSUE and WAIT_ACK.
REQ-022 IDLE to ISSUE SHALL occur when !empty and !uart_busy; on that edge the head byte loads into uart_tx_data, the read pointer advances (pop) and uart_wr is set to 1.
REQ-023 ISSUE to WAIT_ACK SHALL occur unconditionally after exactly one cycle, with uart_wr cleared to 0; uart_wr SHALL therefore be high for exactly one cycle.
REQ-024 WAIT_ACK to IDLE SHALL occur on the first cycle in which uart_busy=1, so that a second strobe is never issued before the transmitter has accepted the first.
REQ-025 uart_tx_data SHALL remain stable from the ISSUE cycle until the next IDLE-to-ISSUE transition.
REQ-026 A simultaneous accepted push and pop SHALL leave level unchanged and update both pointers.
REQ-027 Minimum latency SHALL be as follows: a push into an empty queue with the FSM in IDLE and uart_busy=0 gives uart_wr=1 in the second cycle after the push cycle.
REQ-028 Sustained throughput SHALL be at most one byte per transmitter frame; no byte SHALL be lost or duplicated.
REQ-029 flush SHALL set both pointers equal, set level to 0 and discard any push in the same cycle; it SHALL NOT clear overflow.
REQ-030 flush SHALL NOT alter the FSM; a byte already in ISSUE or WAIT_ACK SHALL complete its handshake.
REQ-031 A pop in the same cycle as flush SHALL be overridden by flush.

Reset
REQ-032 Asserting resetq low SHALL immediately clear both pointers and level and set the FSM to IDLE.
REQ-033 During reset, outputs SHALL be: uart_wr=0, uart_tx_data=8'h00, overflow=0, empty=1, full=0, level=0.
REQ-034 Buffer contents SHALL NOT be reset.
REQ-035 Reset asserted mid-handshake SHALL abort it; uart_wr SHALL drop asynchronously.

Structure
REQ-036 The FSM state encoding and the DEPTH default SHALL reside in a shared package uart_pkg, for reuse by the receive-side logic.
REQ-037 The storage and pointers SHALL be a sub-module sync_fifo (parameters DEPTH, WIDTH); the drain FSM SHALL stay in uart_tx_queue.

Verification
REQ-038 Reset, then push 8'h41 with uart_busy=0 -> uart_wr=1 with uart_tx_data=8'h41 exactly 2 cycles later, for one cycle; empty=1 afterwards.
REQ-039 Hold uart_busy=1 and push 16 bytes 0x00..0x0F -> full=1, level=16; a 17th push 0xFF sets overflow with level still 16; then release busy, pulse busy for 10 cycles after each uart_wr -> outputs 0x00..0x0F in order with no 0xFF.
REQ-040 Push in the same cycle as a pop with level=5 -> level stays 5; the pushed byte is output last.
REQ-041 Push 3 bytes, flush while the first is in WAIT_ACK -> the first byte completes, no further uart_wr, level=0, overflow unchanged.
REQ-042 Set overflow, then assert clr_ovf together with a rejected push -> overflow stays 1; clr_ovf alone next cycle -> overflow=0.
REQ-043 Assert resetq low during ISSUE -> uart_wr=0 immediately, level=0, FSM in IDLE after release.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART drain-state encoding and queue sizing
package uart_pkg;
  localparam int UART_DEPTH = 16;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular buffer with registered occupancy, flush and wrapping pointers
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic do_wr, do_rd;
  // flush beats both a write and a read in the same cycle; flags come only from level_q
  always_comb begin
    do_wr = wr_en && !full && !flush;
    do_rd = rd_en && !empty && !flush;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = flush ? wr_ptr_q : do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d = flush ? '0 : level_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
  // storage is left unreset; only accepted writes touch it
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue drained into a UART transmitter with a one-strobe handshake
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        flush,
  input  logic        clr_ovf,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        overflow,
  output logic        uart_wr,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_busy
);
  tx_state_e state_q, state_d;
  logic [7:0] data_q, data_d, head;
  logic ovf_q, ovf_d, start;
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8), .AW(AW)) u_fifo (
    .clk     (clk),
    .resetq  (resetq),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (start),
    .flush   (flush),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );
  // state, latched byte and sticky overflow registers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= IDLE;
      data_q <= 8'h00;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      ovf_q <= ovf_d;
    end
  end
  // pop only when a byte is available, the transmitter is free and no flush discards it
  always_comb begin
    start = state_q == IDLE && !empty && !uart_busy && !flush;
    state_d = state_q == IDLE ? (start ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT_ACK :
              state_q == WAIT_ACK ? (uart_busy ? IDLE : WAIT_ACK) : IDLE;
    data_d = start ? head : data_q;
    ovf_d = push && full ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
  end
  // strobe is a pure decode of ISSUE so reset drops it without waiting for a clock
  always_comb begin
    uart_wr = state_q == ISSUE;
    uart_tx_data = data_q;
    overflow = ovf_q;
  end
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed and randomized checks against a queue-based reference model
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 1'b0, resetq = 1'b0, push = 1'b0, flush = 1'b0, clr_ovf = 1'b0, force_busy = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic full, empty, overflow, uart_wr, uart_busy;
  logic [AW:0] level;
  logic [7:0] uart_tx_data;
  int checks = 0, errors = 0;
  int busy_cnt = 0, busy_len = 10;
  logic [7:0] mdl_q[$], rx_q[$];
  logic mdl_ovf = 1'b0, prev_wr = 1'b0;
  logic [7:0] exp_b, got_f, exp_f;
  assign uart_busy = force_busy || busy_cnt != 0;
  always #5 clk = ~clk;
  uart_tx_queue dut (
    .clk          (clk),
    .resetq       (resetq),
    .push         (push),
    .push_data    (push_data),
    .flush        (flush),
    .clr_ovf      (clr_ovf),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .uart_wr      (uart_wr),
    .uart_tx_data (uart_tx_data),
    .uart_busy    (uart_busy)
  );
  // reference model and transmitter stand-in, evaluated mid-cycle
  initial forever begin
    @(negedge clk);
    if (!resetq) begin
      mdl_q.delete();
      mdl_ovf = 1'b0;
      busy_cnt = 0;
      prev_wr = 1'b0;
    end else begin
      checks++;
      if (uart_wr && prev_wr) begin
        errors++;
        $display("FAIL wr_pulse: uart_wr=1 on consecutive cycles, required single-cycle strobe");
      end
      if (uart_wr) begin
        rx_q.push_back(uart_tx_data);
        checks++;
        if (mdl_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got byte %02h, required no write", uart_tx_data);
        end else begin
          exp_b = mdl_q.pop_front();
          if (uart_tx_data !== exp_b) begin
            errors++;
            $display("FAIL wr_data: got %02h, required %02h", uart_tx_data, exp_b);
          end
        end
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) busy_cnt--;
      prev_wr = uart_wr;
      got_f = {level, full, empty, overflow};
      exp_f = {5'(mdl_q.size()), mdl_q.size() == DEPTH, mdl_q.size() == 0, mdl_ovf};
      checks++;
      if (got_f !== exp_f) begin
        errors++;
        $display("FAIL status: got level/full/empty/ovf=%0d/%b/%b/%b, required %0d/%b/%b/%b",
                 got_f[7:3], got_f[2], got_f[1], got_f[0], exp_f[7:3], exp_f[2], exp_f[1], exp_f[0]);
      end
      if (push && mdl_q.size() == DEPTH) mdl_ovf = 1'b1;
      else if (clr_ovf) mdl_ovf = 1'b0;
      if (flush) mdl_q.delete();
      else if (push && mdl_q.size() < DEPTH) mdl_q.push_back(push_data);
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      push = 1'b1;
      push_data = 8'(base + i);
      tick();
    end
    push = 1'b0;
  endtask
  task automatic wait_drain();
    int quiet = 0;
    for (int i = 0; i < 2000 && quiet < 3; i++) begin
      tick();
      quiet = (empty && !uart_busy && !uart_wr) ? quiet + 1 : 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL drain_timeout: level=%0d busy=%b, required empty and idle", level, uart_busy);
    end
  endtask
  task automatic test_reset();
    resetq = 1'b0;
    #3;
    checks++;
    if (uart_wr !== 1'b0 || uart_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobe: wr=%b data=%02h, required 0/00", uart_wr, uart_tx_data);
    end
    checks++;
    if (overflow !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL reset_flags: ovf=%b empty=%b full=%b level=%0d, required 0/1/0/0", overflow, empty, full, level);
    end
    tick(2);
    resetq = 1'b1;
    tick();
  endtask
  task automatic test_min_latency();
    rx_q.delete();
    busy_len = 10;
    push = 1'b1;
    push_data = 8'h41;
    tick();
    push = 1'b0;
    checks++;
    if (uart_wr !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: wr=%b one cycle after push, required 0", uart_wr);
    end
    tick();
    checks++;
    if (uart_wr !== 1'b1 || uart_tx_data !== 8'h41) begin
      errors++;
      $display("FAIL latency_issue: wr=%b data=%02h, required 1/41", uart_wr, uart_tx_data);
    end
    tick();
    checks++;
    if (uart_wr !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL latency_after: wr=%b empty=%b, required 0/1", uart_wr, empty);
    end
    wait_drain();
  endtask
  task automatic test_overflow();
    rx_q.delete();
    force_busy = 1'b1;
    busy_len = 10;
    fill(16, 0);
    checks++;
    if (full !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL fill_full: full=%b level=%0d, required 1/16", full, level);
    end
    push = 1'b1;
    push_data = 8'hFF;
    tick();
    push = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b level=%0d, required 1/16", overflow, level);
    end
    force_busy = 1'b0;
    wait_drain();
    checks++;
    if (rx_q.size() != 16) begin
      errors++;
      $display("FAIL drain_count: got %0d bytes, required 16", rx_q.size());
    end else
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i)) begin
          errors++;
          $display("FAIL drain_order[%0d]: got %02h, required %02h", i, rx_q[i], 8'(i));
        end
      end
  endtask
  task automatic test_flush();
    logic ovf_before;
    rx_q.delete();
    busy_len = 10;
    force_busy = 1'b0;
    ovf_before = overflow;
    push = 1'b1;
    push_data = 8'hC1;
    tick();
    push_data = 8'hC2;
    tick();
    checks++;
    if (uart_wr !== 1'b1 || uart_tx_data !== 8'hC1) begin
      errors++;
      $display("FAIL flush_issue: wr=%b data=%02h, required 1/c1", uart_wr, uart_tx_data);
    end
    push_data = 8'hC3;
    tick();
    push = 1'b0;
    flush = 1'b1;
    checks++;
    if (uart_wr !== 1'b0 || level !== 5'd2) begin
      errors++;
      $display("FAIL flush_wait: wr=%b level=%0d, required 0/2", uart_wr, level);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (level !== 5'd0 || overflow !== ovf_before) begin
      errors++;
      $display("FAIL flush_level: level=%0d ovf=%b, required 0/%b", level, overflow, ovf_before);
    end
    wait_drain();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hC1 || overflow !== ovf_before) begin
      errors++;
      $display("FAIL flush_complete: bytes=%0d ovf=%b, required 1 byte c1 and ovf=%b", rx_q.size(), overflow, ovf_before);
    end
  endtask
  task automatic test_clr_ovf();
    force_busy = 1'b1;
    fill(16, 8'h80);
    push = 1'b1;
    push_data = 8'hEE;
    clr_ovf = 1'b1;
    tick();
    push = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL clr_collide: ovf=%b level=%0d, required 1/16", overflow, level);
    end
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_alone: ovf=%b, required 0", overflow);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL clr_flush: level=%0d empty=%b, required 0/1", level, empty);
    end
    force_busy = 1'b0;
  endtask
  task automatic test_push_pop();
    rx_q.delete();
    force_busy = 1'b1;
    busy_len = 3;
    fill(5, 8'h50);
    checks++;
    if (level !== 5'd5) begin
      errors++;
      $display("FAIL pp_level_pre: level=%0d, required 5", level);
    end
    force_busy = 1'b0;
    push = 1'b1;
    push_data = 8'hA5;
    tick();
    push = 1'b0;
    checks++;
    if (level !== 5'd5 || uart_wr !== 1'b1) begin
      errors++;
      $display("FAIL pp_level: level=%0d wr=%b, required 5/1", level, uart_wr);
    end
    wait_drain();
    checks++;
    if (rx_q.size() != 6) begin
      errors++;
      $display("FAIL pp_count: got %0d bytes, required 6", rx_q.size());
    end else if (rx_q[5] !== 8'hA5) begin
      errors++;
      $display("FAIL pp_last: got %02h, required a5", rx_q[5]);
    end
  endtask
  task automatic test_reset_mid();
    busy_len = 10;
    force_busy = 1'b0;
    push = 1'b1;
    push_data = 8'h11;
    tick();
    push_data = 8'h22;
    tick();
    push = 1'b0;
    checks++;
    if (uart_wr !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_issue: wr=%b, required 1", uart_wr);
    end
    #2 resetq = 1'b0;
    #1;
    checks++;
    if (uart_wr !== 1'b0 || level !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async: wr=%b level=%0d empty=%b, required 0/0/1", uart_wr, level, empty);
    end
    tick(2);
    resetq = 1'b1;
    tick();
    checks++;
    if (uart_wr !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid_release: wr=%b level=%0d, required 0/0", uart_wr, level);
    end
    push = 1'b1;
    push_data = 8'h33;
    tick();
    push = 1'b0;
    tick();
    checks++;
    if (uart_wr !== 1'b1 || uart_tx_data !== 8'h33) begin
      errors++;
      $display("FAIL rst_mid_idle: wr=%b data=%02h, required 1/33", uart_wr, uart_tx_data);
    end
    wait_drain();
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      push = $urandom_range(0, 2) == 0;
      push_data = 8'($urandom);
      flush = $urandom_range(0, 59) == 0;
      clr_ovf = $urandom_range(0, 24) == 0;
      force_busy = $urandom_range(0, 9) == 0;
      busy_len = $urandom_range(1, 4);
      tick();
    end
    push = 1'b0;
    flush = 1'b0;
    clr_ovf = 1'b0;
    force_busy = 1'b0;
    wait_drain();
  endtask
  initial begin
    test_reset();
    test_min_latency();
    test_overflow();
    test_flush();
    test_clr_ovf();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
